mem_resp: RTL and testbench

- Data-memory responder: the memory end of the core's load/store request/response interface.
- Accepts one request at a time from the core, performs a byte, half or word access into internal word-organised storage, and returns a buffered response after a fixed latency.
- Load sign/zero extension is decoded from the RISC-V funct3 field.

---
 rtl/mem_resp.sv | 196 +++++++++++++++++++
 tb/tb_mem_resp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp.sv
// Data-memory responder: one load/store request at a time, response after LATENCY cycles.
// Optional build macro MISALIGN_ERR_EN: misaligned half/word accesses return an error.
module mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            exec;

  logic            lat_we;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [2:0]      lat_f3;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            x_we;
  logic [31:0]     x_addr;
  logic [31:0]     x_wdata;
  logic [2:0]      x_f3;
  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic            in_range;
  logic            misalign;
  logic            ld_ok;
  logic            st_ok;
  logic            x_err;
  logic [31:0]     ld_data;
  logic [3:0]      wmask;
  logic [31:0]     wrep;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    exec    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_n = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_n = RESP;
            exec    = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = RESP;
          exec    = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // With LATENCY == 1 the access runs at the accept edge, so operands come straight from the request.
  always_comb begin
    x_we    = (state == IDLE) ? req_we     : lat_we;
    x_addr  = (state == IDLE) ? req_addr   : lat_addr;
    x_wdata = (state == IDLE) ? req_wdata  : lat_wdata;
    x_f3    = (state == IDLE) ? req_funct3 : lat_f3;
  end

  always_comb begin
    in_range = (x_addr[31:AW+2] == '0);
    idx      = x_addr[AW+1:2];
    word     = mem[idx];
    case (x_addr[1:0])
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v   = x_addr[1] ? word[31:16] : word[15:0];

    misalign = 1'b0;
`ifdef MISALIGN_ERR_EN
    case (x_f3[1:0])
      2'b01:   misalign = x_addr[0];
      2'b10:   misalign = |x_addr[1:0];
      default: misalign = 1'b0;
    endcase
`endif

    ld_ok   = 1'b0;
    st_ok   = 1'b0;
    ld_data = '0;
    wmask   = '0;
    wrep    = '0;
    case (x_f3)
      3'b000: begin
        ld_ok   = 1'b1;
        st_ok   = 1'b1;
        ld_data = {{24{byte_v[7]}}, byte_v};
        wmask   = 4'b0001 << x_addr[1:0];
        wrep    = {4{x_wdata[7:0]}};
      end
      3'b001: begin
        ld_ok   = 1'b1;
        st_ok   = 1'b1;
        ld_data = {{16{half_v[15]}}, half_v};
        wmask   = x_addr[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{x_wdata[15:0]}};
      end
      3'b010: begin
        ld_ok   = 1'b1;
        st_ok   = 1'b1;
        ld_data = word;
        wmask   = 4'b1111;
        wrep    = x_wdata;
      end
      3'b100: begin
        ld_ok   = 1'b1;
        ld_data = {24'b0, byte_v};
      end
      3'b101: begin
        ld_ok   = 1'b1;
        ld_data = {16'b0, half_v};
      end
      default: begin
        ld_ok = 1'b0;
        st_ok = 1'b0;
      end
    endcase

    x_err = !in_range || misalign || (x_we ? !st_ok : !ld_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (req_valid && req_ready) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_f3    <= req_funct3;
      end
      if (exec) begin
        rsp_err   <= x_err;
        rsp_rdata <= (x_err || x_we) ? '0 : ld_data;
      end
    end
  end

  // Storage is not reset; rst_n gating keeps an in-flight store from landing during reset.
  always_ff @(posedge clk) begin
    if (exec && rst_n && x_we && !x_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp (LATENCY = 3): driver queues expected responses, monitor checks them.
module tb_mem_resp;

  localparam int unsigned DW  = 1024;
  localparam int unsigned LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  mem_resp #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing expected", rsp_rdata, rsp_err);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
      end
    end
  end

  // Drives one request from IDLE; when push is set, also measures accept-to-rsp_valid latency.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] er, input logic ee, input bit push);
    int   cyc;
    exp_t e;
    if (push) begin
      e.rdata = er;
      e.err   = ee;
      sbq.push_back(e);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (push) begin
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
        @(posedge clk);
        #1 cyc++;
      end
      check("latency", 32'(cyc), 32'(LAT));
    end
  endtask

  task automatic finish_rsp();
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    check("rsp_done", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [2:0] f3, input logic [31:0] er, input logic ee);
    issue(we, addr, wdata, f3, er, ee, 1'b1);
    finish_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    #1 check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // word store/load and sub-word extension
    op(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    op(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
    op(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
    op(1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0);
    op(1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    op(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);

    // byte and half lane stores
    op(1'b1, 32'h11, 32'h12345677, 3'b000, 32'h0, 1'b0);
    op(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD77EF, 1'b0);
    op(1'b1, 32'h12, 32'hAAAA1234, 3'b001, 32'h0, 1'b0);
    op(1'b0, 32'h10, 32'h0, 3'b010, 32'h123477EF, 1'b0);

    // response back-pressure; a request offered during RESP must be ignored
    op(1'b1, 32'h40, 32'h11111111, 3'b010, 32'h0, 1'b0);
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 3'b010, 32'h123477EF, 1'b0, 1'b1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h40;
    req_wdata  = 32'h99;
    req_funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'h123477EF);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 check("req_ready_after_rsp", {31'b0, req_ready}, 32'd1);
    op(1'b0, 32'h40, 32'h0, 3'b010, 32'h11111111, 1'b0);

    // error cases leave storage untouched
    op(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    op(1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, 1'b1);
    op(1'b1, 32'h10, 32'hFFFFFFFF, 3'b011, 32'h0, 1'b1);
    op(1'b0, 32'h10, 32'h0, 3'b010, 32'h123477EF, 1'b0);
    op(1'b1, 32'h0, 32'h00000077, 3'b010, 32'h0, 1'b0);
    op(1'b1, 32'h1000, 32'hABCDABCD, 3'b010, 32'h0, 1'b1);
    op(1'b0, 32'h0, 32'h0, 3'b010, 32'h00000077, 1'b0);

    // misaligned word store
    op(1'b1, 32'h20, 32'h01020304, 3'b010, 32'h0, 1'b0);
`ifdef MISALIGN_ERR_EN
    op(1'b1, 32'h22, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1);
    op(1'b0, 32'h20, 32'h0, 3'b010, 32'h01020304, 1'b0);
`else
    op(1'b1, 32'h22, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
    op(1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);
`endif

    // reset during WAIT drops the pending store
    op(1'b1, 32'h30, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
    issue(1'b1, 32'h30, 32'h55, 3'b010, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("wait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    op(1'b0, 32'h30, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);

    repeat (3) @(posedge clk);
    #1 check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
